// File: rtl/multi_hex_display_pkg.sv
// Shared definitions for the multi-digit hex display: mode encodings and segment glyphs.
package multi_hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    // Active-high glyphs for 0..F, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [0:15][6:0] SEG_GLYPH = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/multi_hex_display_if.sv
// Control inputs and display outputs of the multi-digit hex display.
interface multi_hex_display_if
    import multi_hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6
);
    localparam int unsigned CountW = $clog2(NUM_DIGITS + 1);

    logic                    Load;
    logic [3:0]              Data;
    mode_e                   Mode;
    logic [7*NUM_DIGITS-1:0] HEX;
    logic [CountW-1:0]       Count;

    modport master (output Load, Data, Mode, input HEX, Count);
    modport slave  (input Load, Data, Mode, output HEX, Count);

endinterface

// File: rtl/multi_hex_display_seg7_decoder.sv
// Combinational hex-to-7-segment decoder with blanking and selectable output polarity.
module seg7_decoder
    import multi_hex_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] value_i,
    input  logic       valid_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = '0;
        if (valid_i && !blank_i) begin
            seg_hi = SEG_GLYPH[value_i];
        end
        seg_o = ACTIVE_LOW ? ~seg_hi : seg_hi;
    end

endmodule

// File: rtl/multi_hex_display.sv
// Shift-in hex digit buffer driving NUM_DIGITS 7-segment displays with rotate and blink modes.
module multi_hex_display
    import multi_hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned TICK_DIV   = 25000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input logic                CLOCK_50,
    input logic                Reset,
    multi_hex_display_if.slave bus_io
);
    localparam int unsigned CountW   = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TickW    = $clog2(TICK_DIV);
    localparam logic [6:0]  SegBlank = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]      valid_q, valid_d;
    logic                       load_q;
    logic [TickW-1:0]           tick_cnt_q, tick_cnt_d;
    logic                       phase_q, phase_d;
    logic [CountW-1:0]          count_q, count_d, count_out_q;
    logic [7*NUM_DIGITS-1:0]    hex_q, hex_d;
    logic                       load_evt, tick, blank;

    assign load_evt   = bus_io.Load & ~load_q;
    assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    // Blanking is gated by the live mode so leaving blink restores the display at once.
    assign blank      = phase_q & (bus_io.Mode == MODE_BLINK);

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        if (load_evt) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                digit_d[i] = digit_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            digit_d[0] = bus_io.Data;
            valid_d[0] = 1'b1;
        end else if (tick) begin
            case (bus_io.Mode)
                MODE_ROT_L: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digit_d[i] = digit_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
                        valid_d[i] = valid_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
                    end
                end
                MODE_ROT_R: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digit_d[i] = digit_q[(i + 1) % NUM_DIGITS];
                        valid_d[i] = valid_q[(i + 1) % NUM_DIGITS];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (load_evt && (count_q != CountW'(NUM_DIGITS))) begin
            count_d = count_q + 1'b1;
        end
        phase_d = 1'b0;
        if (bus_io.Mode == MODE_BLINK) begin
            phase_d = tick ? ~phase_q : phase_q;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dec
        seg7_decoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_dec (
            .value_i(digit_q[g]),
            .valid_i(valid_q[g]),
            .blank_i(blank),
            .seg_o  (hex_d[7*g +: 7])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            digit_q     <= '0;
            valid_q     <= '0;
            load_q      <= 1'b0;
            tick_cnt_q  <= '0;
            phase_q     <= 1'b0;
            count_q     <= '0;
            count_out_q <= '0;
            hex_q       <= {NUM_DIGITS{SegBlank}};
        end else begin
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            load_q      <= bus_io.Load;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            count_out_q <= count_q;
            hex_q       <= hex_d;
        end
    end

    assign bus_io.HEX   = hex_q;
    assign bus_io.Count = count_out_q;

endmodule

// File: tb/tb_multi_hex_display.sv
// Directed self-checking bench for multi_hex_display (4 digits, tick every 4 cycles, active-low).
module tb_multi_hex_display;
    import multi_hex_display_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errs = 0;
    int   edges = 0;

    multi_hex_display_if #(.NUM_DIGITS(4)) dif ();

    multi_hex_display #(
        .NUM_DIGITS(4),
        .TICK_DIV  (4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .CLOCK_50(clk),
        .Reset   (rst),
        .bus_io  (dif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edges counted since reset release; the DUT ticks on every 4th of them.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) edges = 0;
            else edges++;
            @(negedge clk);
        end
    endtask

    task automatic to_tick_edge();
        while (((edges + 1) % 4) != 0) step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dif.Load = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic load_digit(input logic [3:0] d);
        dif.Data = d;
        dif.Load = 1'b1;
        step(1);
        dif.Load = 1'b0;
        step(1);
    endtask

    task automatic check_digits(input string tag, input logic [6:0] h0, input logic [6:0] h1,
                                input logic [6:0] h2, input logic [6:0] h3, input int cnt);
        check_eq({tag, " hex"}, 32'(dif.HEX), 32'({h3, h2, h1, h0}));
        check_eq({tag, " count"}, 32'(dif.Count), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [27:0] shown;
        logic [27:0] blanked;
        shown   = {7'h7F, 7'h79, 7'h24, 7'h30};
        blanked = 28'hFFFFFFF;
        dif.Load = 1'b0;
        dif.Data = 4'h0;
        dif.Mode = MODE_STATIC;
        @(negedge clk);

        // Reset state
        step(2);
        check_digits("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0);
        rst = 1'b0;

        // Static mode, three digits
        load_digit(4'h1);
        check_digits("load1", 7'h79, 7'h7F, 7'h7F, 7'h7F, 1);
        load_digit(4'h2);
        load_digit(4'h3);
        check_digits("load123", 7'h30, 7'h24, 7'h79, 7'h7F, 3);

        // Rotate left one tick, then rotate right one tick
        to_tick_edge();
        dif.Mode = MODE_ROT_L;
        step(1);
        dif.Mode = MODE_STATIC;
        step(1);
        check_digits("rotl", 7'h7F, 7'h30, 7'h24, 7'h79, 3);
        to_tick_edge();
        dif.Mode = MODE_ROT_R;
        step(1);
        dif.Mode = MODE_STATIC;
        step(1);
        check_digits("rotr", 7'h30, 7'h24, 7'h79, 7'h7F, 3);

        // Blink: 4 cycles blank, 4 cycles shown, then exit blink while blanked
        to_tick_edge();
        dif.Mode = MODE_BLINK;
        step(1);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check_eq($sformatf("blink%0d", k), 32'(dif.HEX), 32'((k <= 4) ? blanked : shown));
        end
        step(1);
        check_eq("blink9", 32'(dif.HEX), 32'(blanked));
        dif.Mode = MODE_STATIC;
        step(1);
        check_eq("blink exit", 32'(dif.HEX), 32'(shown));
        check_eq("blink count", 32'(dif.Count), 32'd3);

        // Saturation with five loads
        do_reset();
        load_digit(4'hA);
        load_digit(4'hB);
        load_digit(4'hC);
        load_digit(4'hD);
        load_digit(4'hE);
        check_digits("sat", 7'h06, 7'h21, 7'h46, 7'h03, 4);

        // Load held high yields a single shift
        do_reset();
        dif.Data = 4'h5;
        dif.Load = 1'b1;
        step(5);
        dif.Data = 4'h7;
        step(5);
        check_digits("held", 7'h12, 7'h7F, 7'h7F, 7'h7F, 1);
        dif.Load = 1'b0;
        step(1);

        // Load event on a tick edge in rotate-left: shift only
        to_tick_edge();
        dif.Mode = MODE_ROT_L;
        dif.Data = 4'h9;
        dif.Load = 1'b1;
        step(1);
        dif.Load = 1'b0;
        dif.Mode = MODE_STATIC;
        step(1);
        check_digits("load on tick", 7'h10, 7'h12, 7'h7F, 7'h7F, 2);

        // Reset during rotation
        dif.Mode = MODE_ROT_L;
        step(3);
        rst = 1'b1;
        step(1);
        check_digits("reset rot", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0);

        // Reset wins over a coincident load edge
        dif.Mode = MODE_STATIC;
        dif.Data = 4'h3;
        dif.Load = 1'b1;
        step(1);
        dif.Load = 1'b0;
        rst = 1'b0;
        step(2);
        check_digits("reset prio", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/multi_hex_display.md
MULTI_HEX_DISPLAY -- requirements
Module: multi_hex_display

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of 7-segment digits driven (legal 1..8).
REQ-002 Parameter TICK_DIV, default 25000000, CLOCK_50 cycles per scroll/blink step (legal >= 2).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = segment outputs active-low (DE-series HEX), 0 = active-high.
REQ-004 CLOCK_50  input  1  sole clock, all state updates on its rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 Load  input  1  level input (from a pushbuttons/debouncer); each rising edge shifts in one digit.
REQ-007 Data  input  4  hex value shifted in on a Load rising edge.
REQ-008 Mode  input  2  00 static, 01 rotate left, 10 rotate right, 11 blink.
REQ-009 HEX  output  7*NUM_DIGITS  segment bus; digit i at bits [7i+6:7i], bit 0 = segment a ... bit 6 = segment g; registered.
REQ-010 Count  output  $clog2(NUM_DIGITS+1)  number of valid (non-blank) digits; registered.

Function
REQ-011 The block shall hold a NUM_DIGITS x 4-bit digit buffer plus a NUM_DIGITS-bit valid mask; invalid digits display blank (all segments off).
REQ-012 Load edge detection shall use a registered copy load_q; a load event is Load=1 and load_q=0 at a clock edge; Load held high yields exactly one event.
REQ-013 On a load event, digit[i] <= digit[i-1] for i>=1, digit[0] <= Data, valid <= {valid[N-2:0],1}; digit[N-1] is discarded.
REQ-014 Count shall increment by 1 on each load event, saturating at NUM_DIGITS; rotation and blink shall not change Count.
REQ-015 A free-running tick counter shall count 0..TICK_DIV-1 and wrap to 0; tick is asserted in the cycle the counter equals TICK_DIV-1; Mode changes shall not reset it.
REQ-016 Mode 01: on tick, buffer and valid mask rotate one position toward digit N-1, digit N-1 wrapping to digit 0.
REQ-017 Mode 10: on tick, buffer and valid mask rotate one position toward digit 0, digit 0 wrapping to digit N-1.
REQ-018 Mode 11: on tick, blink phase toggles; phase=1 blanks all digits without altering buffer or mask; in modes 00/01/10 phase is forced to 0.
REQ-019 Load event coincident with tick: load shift is applied, rotation for that tick is dropped; blink toggle still applies.
REQ-020 Latency: buffer updates at the edge the event is detected; HEX and Count reflect it at the following edge (2 edges after Load first sampled high).
REQ-021 Segment code per digit: 0..F standard DE-series glyphs (b and d lower-case); ACTIVE_LOW=1 output is bitwise inverse of active-high code.
REQ-022 Active-low codes 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); blank = 7F.

Reset
REQ-023 With Reset=1 at a clock edge: buffer 0, valid mask 0, load_q 0, tick counter 0, blink phase 0, Count 0, HEX all blank (7F per digit when ACTIVE_LOW=1, 00 otherwise).
REQ-024 Reset shall take priority over load events and ticks in the same cycle; Reset asserted mid-rotation or mid-blink shall abort it with no residual state.

Structure
REQ-025 A shared package shall hold the Mode encodings (MODE_STATIC, MODE_ROT_L, MODE_ROT_R, MODE_BLINK) and the 16-entry segment glyph table.
REQ-026 One combinational sub-module seg7_decoder (4-bit value, valid, blank, ACTIVE_LOW -> 7-bit segments) shall be instantiated NUM_DIGITS times.

Verification (NUM_DIGITS=4, TICK_DIV=4, ACTIVE_LOW=1)
REQ-027 Reset 2 cycles -> HEX=28'hFFFFFFF (all 7F), Count=0.
REQ-028 Mode 00, load 1,2,3 -> HEX0=30, HEX1=24, HEX2=79, HEX3=7F, Count=3.
REQ-029 Mode 00, load A,B,C,D,E -> HEX0=06, HEX1=21, HEX2=46, HEX3=03, Count=4 (saturated).
REQ-030 After REQ-028 state, Mode 01, one tick -> HEX0=7F, HEX1=30, HEX2=24, HEX3=79; Mode 10, one tick -> back to REQ-028 values.
REQ-031 Mode 11 with digits loaded -> all digits 7F for 4 cycles, restored for 4 cycles, alternating; switching to Mode 00 restores display next cycle.
REQ-032 Load held high 10 cycles -> single shift; load event on tick cycle in Mode 01 -> shift applied, no rotation; Reset during Mode 01 -> REQ-027 values next cycle.
